bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, address bus width.
REQ-002 Parameter REG_WIDTH, default 8, data bus width.
REQ-003 Parameter DMA_TRIG_ADDR, default 16'h4014, write address that starts OAM DMA.
REQ-004 Parameter OAM_DATA_ADDR, default 16'h2004, DMA write destination.
REQ-005 phi1  input  1  clock; all state updates on posedge phi1.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 fetch_req  input  1  fetcher requests a read this cycle.
REQ-008 fetch_addr  input  ADDR_WIDTH  fetcher read address.
REQ-009 exec_req  input  1  execute unit requests an access this cycle.
REQ-010 exec_we  input  1  execute access is a write.
REQ-011 exec_addr  input  ADDR_WIDTH  execute access address.
REQ-012 exec_wdata  input  REG_WIDTH  execute write data.
REQ-013 mem_rdata  input  REG_WIDTH  memory read data, valid in the same cycle as mem_addr.
REQ-014 mem_addr  output  ADDR_WIDTH  shared memory address.
REQ-015 mem_wdata  output  REG_WIDTH  shared memory write data.
REQ-016 mem_we  output  1  shared memory write strobe.
REQ-017 fetch_gnt  output  1  fetcher owns the bus this cycle.
REQ-018 exec_gnt  output  1  execute unit owns the bus this cycle.
REQ-019 dma_busy  output  1  DMA owns the bus; CPU requesters stalled.

Function
REQ-020 Grants and mem_* outputs SHALL be combinational from the requests and registered state; at most one grant is high per cycle.
REQ-021 With DMA idle, a sole requester SHALL be granted in the same cycle; when both request, round-robin applies: the requester not granted most recently wins, and a last_winner flop updates on each grant.
REQ-022 Granted requester's address/we/wdata SHALL drive mem_*; a fetch grant drives mem_we=0.
REQ-023 With no grant and DMA idle, mem_addr=0, mem_wdata=0, mem_we=0.
REQ-024 A parity flop SHALL toggle every cycle.
REQ-025 DMA FSM states: IDLE, ALIGN, READ, WRITE.
REQ-026 IDLE->ALIGN when exec_gnt, exec_we=1 and exec_addr==DMA_TRIG_ADDR; page<=exec_wdata[7:0], idx<=0; the triggering write still goes to memory.
REQ-027 ALIGN lasts 1 cycle if parity==0 on entry, 2 cycles if parity==1, then goes to READ.
REQ-028 READ: mem_addr={page,idx}, mem_we=0; buf<=mem_rdata; next WRITE.
REQ-029 WRITE: mem_addr=OAM_DATA_ADDR, mem_wdata=buf, mem_we=1; idx<=idx+1 (8-bit wrap); if idx==8'hFF go IDLE, else READ.
REQ-030 dma_busy SHALL be high in every non-IDLE state; fetch_gnt=exec_gnt=0 while dma_busy, regardless of requests.
REQ-031 Transfer is exactly 256 READ/WRITE pairs; dma_busy spans 513 cycles (even entry parity) or 514 (odd).
REQ-032 Requests held through DMA SHALL be granted in the first cycle after return to IDLE, round-robin preserved.

Reset
REQ-033 While reset_n=0 at posedge phi1: FSM<=IDLE, idx<=0, page<=0, buf<=0, parity<=0, last_winner<=exec (fetch wins first conflict).
REQ-034 Reset mid-DMA SHALL abort the transfer; dma_busy=0 and normal arbitration from the following cycle.

Configuration
REQ-035 Macro OAM_DMA_EN: defined -> DMA FSM, page/idx/buf/parity registers present per REQ-024..032.
REQ-036 OAM_DMA_EN undefined -> no DMA logic; writes to DMA_TRIG_ADDR are ordinary writes; dma_busy tied 0.

Verification
REQ-037 Reset with both requests high -> after reset release, first grant fetch_gnt=1, mem_we=0, mem_addr=fetch_addr.
REQ-038 fetch_req=exec_req=1 for 4 cycles -> grants fetch,exec,fetch,exec; one-hot every cycle.
REQ-039 Exec write 8'h02 to 16'h4014 with parity 0 on ALIGN entry -> dma_busy 513 cycles; reads 16'h0200..16'h02FF in order, each followed by a write to 16'h2004 of the read byte; no CPU grants.
REQ-040 Same trigger with parity 1 on ALIGN entry -> dma_busy 514 cycles, identical data sequence.
REQ-041 reset_n=0 when idx==8'h40 -> next cycle dma_busy=0, mem_we=0; pending fetch_req granted after reset release.
REQ-042 OAM_DMA_EN undefined, exec write 8'h02 to 16'h4014 -> single mem write, dma_busy stays 0, fetch granted next cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: round-robin between fetcher and execute unit, with an
// optional OAM DMA engine (enable with `define OAM_DMA_EN) that steals the bus.
module bus_arbiter #(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    REG_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] DMA_TRIG_ADDR = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [REG_WIDTH-1:0]  exec_wdata,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic                  mem_we,
  output logic                  fetch_gnt,
  output logic                  exec_gnt,
  output logic                  dma_busy
);

  // Handshake: a requester holds *_req (and its address/data) until it sees
  // its *_gnt high in the same cycle; the access completes in that cycle.

  logic last_winner_q, last_winner_d;  // 1 = execute unit won most recently
  logic dma_active;

  always_comb begin
    fetch_gnt     = 1'b0;
    exec_gnt      = 1'b0;
    if (!dma_active) begin
      if (fetch_req && exec_req) begin
        if (last_winner_q) fetch_gnt = 1'b1;
        else               exec_gnt  = 1'b1;
      end else if (fetch_req) begin
        fetch_gnt = 1'b1;
      end else if (exec_req) begin
        exec_gnt = 1'b1;
      end
    end
    last_winner_d = last_winner_q;
    if (fetch_gnt) last_winner_d = 1'b0;
    if (exec_gnt)  last_winner_d = 1'b1;
  end

`ifdef OAM_DMA_EN
  typedef enum logic [1:0] {DMA_IDLE, DMA_ALIGN, DMA_READ, DMA_WRITE} dma_state_e;

  dma_state_e           state_q, state_d;
  logic [7:0]           page_q, page_d;
  logic [7:0]           idx_q, idx_d;
  logic [REG_WIDTH-1:0] buf_q, buf_d;
  logic                 parity_q, parity_d;
  logic                 dma_busy_q;

  assign dma_active = dma_busy_q;
  assign dma_busy   = dma_busy_q;

  // ALIGN exits on the first cycle it sees parity 0, so an odd entry parity
  // naturally costs one extra cycle.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    parity_d = ~parity_q;
    case (state_q)
      DMA_IDLE: begin
        if (exec_gnt && exec_we && (exec_addr == DMA_TRIG_ADDR)) begin
          state_d = DMA_ALIGN;
          page_d  = exec_wdata[7:0];
          idx_d   = 8'h00;
        end
      end
      DMA_ALIGN: begin
        if (!parity_q) state_d = DMA_READ;
      end
      DMA_READ: begin
        buf_d   = mem_rdata;
        state_d = DMA_WRITE;
      end
      DMA_WRITE: begin
        idx_d   = 8'(idx_q + 8'd1);
        state_d = (idx_q == 8'hFF) ? DMA_IDLE : DMA_READ;
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      state_q       <= DMA_IDLE;
      page_q        <= 8'h00;
      idx_q         <= 8'h00;
      buf_q         <= '0;
      parity_q      <= 1'b0;
      dma_busy_q    <= 1'b0;
      last_winner_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      page_q        <= page_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      parity_q      <= parity_d;
      dma_busy_q    <= (state_d != DMA_IDLE);
      last_winner_q <= last_winner_d;
    end
  end
`else
  logic unused_dma;

  assign dma_active = 1'b0;
  assign dma_busy   = 1'b0;
  assign unused_dma = ^{mem_rdata, DMA_TRIG_ADDR, OAM_DATA_ADDR};

  always_ff @(posedge phi1) begin
    if (!reset_n) last_winner_q <= 1'b1;
    else          last_winner_q <= last_winner_d;
  end
`endif

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (fetch_gnt) begin
      mem_addr = fetch_addr;
    end else if (exec_gnt) begin
      mem_addr  = exec_addr;
      mem_wdata = exec_wdata;
      mem_we    = exec_we;
    end
`ifdef OAM_DMA_EN
    if (state_q == DMA_READ) begin
      mem_addr = ADDR_WIDTH'({page_q, idx_q});
    end else if (state_q == DMA_WRITE) begin
      mem_addr  = OAM_DATA_ADDR;
      mem_wdata = buf_q;
      mem_we    = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table, random arbitration against a reference
// model, and DMA / reset-abort / plain-write sequences chosen by OAM_DMA_EN.
module tb_bus_arbiter;

  logic        phi1 = 1'b0;
  logic        reset_n;
  logic        fetch_req, exec_req, exec_we;
  logic [15:0] fetch_addr, exec_addr;
  logic [7:0]  exec_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, fetch_gnt, exec_gnt, dma_busy;

  logic [27:0] obs;
  logic [24:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        model_last;  // 1 = execute unit won most recently

  bus_arbiter dut (
    .phi1(phi1), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .exec_req(exec_req), .exec_we(exec_we), .exec_addr(exec_addr),
    .exec_wdata(exec_wdata), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .fetch_gnt(fetch_gnt), .exec_gnt(exec_gnt), .dma_busy(dma_busy)
  );

  // clock / reset
  always #5 phi1 = ~phi1;

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  assign mem_rdata = mem_model(mem_addr);
  assign obs = {fetch_gnt, exec_gnt, mem_we, dma_busy, mem_addr, mem_wdata};

  function automatic logic [27:0] pack(input logic fg, input logic eg, input logic we,
                                       input logic busy, input logic [15:0] a,
                                       input logic [7:0] d);
    return {fg, eg, we, busy, a, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge phi1);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic f, input logic e, input logic we,
                       input logic [15:0] fa, input logic [15:0] ea, input logic [7:0] wd);
    fetch_req  = f;
    exec_req   = e;
    exec_we    = we;
    fetch_addr = fa;
    exec_addr  = ea;
    exec_wdata = wd;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1, 1, 0, 16'h1234, 16'hABCD, 8'h55);
    tick();
    tick();
    reset_n = 1'b1;
    cyc = 0;
    model_last = 1'b1;
  endtask

  typedef struct {
    logic f, e, we;
    logic [15:0] fa, ea;
    logic [7:0] wd;
    logic efg, eeg;
    logic [15:0] eaddr;
    logic ewe;
    logic [7:0] ewd;
  } vec_t;

  vec_t vecs[11];

  task automatic random_phase(input int n);
    logic f, e, we, xfg, xeg;
    logic [15:0] fa, ea;
    logic [7:0] wd;
    logic [27:0] x;
    for (int i = 0; i < n; i++) begin
      f  = 1'($urandom_range(0, 1));
      e  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      fa = 16'($urandom_range(0, 16'hFFFF));
      ea = 16'($urandom_range(0, 16'hFFFF));
      wd = 8'($urandom_range(0, 255));
      if (ea == 16'h4014) ea = 16'h4015;
      drive(f, e, we, fa, ea, wd);
      // The requester that did not win last time gets priority on a conflict.
      xfg = f && (!e || model_last);
      xeg = e && !xfg;
      if (xfg)      x = pack(1, 0, 0, 0, fa, 8'h00);
      else if (xeg) x = pack(0, 1, we, 0, ea, wd);
      else          x = pack(0, 0, 0, 0, 16'h0000, 8'h00);
      #2;
      check("random_arb", obs, x);
      if (xfg) model_last = 1'b0;
      if (xeg) model_last = 1'b1;
      tick();
    end
  endtask

`ifdef OAM_DMA_EN
  task automatic run_dma(input bit odd);
    int busy_cnt, align_len;
    bit done;
    logic [24:0] e;
    drive(0, 0, 0, 16'h0000, 16'h0000, 8'h00);
    if (((cyc + 1) % 2) != int'(odd)) tick();
    drive(0, 1, 1, 16'h0000, 16'h4014, 8'h02);
    #2;
    check("dma_trigger_write", obs, pack(0, 1, 1, 0, 16'h4014, 8'h02));
    model_last = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({1'b0, 16'(16'h0200 + i), 8'h00});
      exp_q.push_back({1'b1, 16'h2004, mem_model(16'(16'h0200 + i))});
    end
    align_len = odd ? 2 : 1;
    drive(1, 1, 0, 16'h0123, 16'h0456, 8'h00);
    busy_cnt = 0;
    done = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      #2;
      if (!dma_busy) begin
        done = 1;
      end else begin
        if (busy_cnt < align_len) begin
          check("dma_align", obs, pack(0, 0, 0, 1, 16'h0000, 8'h00));
        end else if (exp_q.size() == 0) begin
          check("dma_extra_cycle", 64'(busy_cnt), 64'(align_len + 512));
        end else begin
          e = exp_q.pop_front();
          check("dma_xfer", obs, pack(0, 0, e[24], 1, e[23:8], e[7:0]));
        end
        busy_cnt++;
        tick();
      end
    end
    check("dma_finished", 64'(done), 64'd1);
    check("dma_busy_len", 64'(busy_cnt), odd ? 64'd514 : 64'd513);
    check("dma_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check("post_dma_fetch", obs, pack(1, 0, 0, 0, 16'h0123, 8'h00));
    model_last = 1'b0;
    tick();
    #2;
    check("post_dma_exec", obs, pack(0, 1, 0, 0, 16'h0456, 8'h00));
    model_last = 1'b1;
    tick();
  endtask

  task automatic run_dma_reset();
    bit found;
    drive(0, 1, 1, 16'h0000, 16'h4014, 8'h02);
    #2;
    check("abort_trigger", obs, pack(0, 1, 1, 0, 16'h4014, 8'h02));
    tick();
    drive(1, 0, 0, 16'h0777, 16'h0000, 8'h00);
    found = 0;
    for (int c = 0; c < 600 && !found; c++) begin
      #2;
      if (dma_busy && !mem_we && mem_addr == 16'h0240) found = 1;
      else tick();
    end
    check("abort_reached_idx40", 64'(found), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    cyc = 0;
    model_last = 1'b1;
    #2;
    check("abort_after_reset", obs, pack(1, 0, 0, 0, 16'h0777, 8'h00));
    model_last = 1'b0;
    tick();
  endtask
`else
  task automatic run_plain_trigger();
    drive(0, 1, 1, 16'h0000, 16'h4014, 8'h02);
    #2;
    check("plain_trig_write", obs, pack(0, 1, 1, 0, 16'h4014, 8'h02));
    model_last = 1'b1;
    tick();
    drive(1, 1, 0, 16'h0300, 16'h0500, 8'h00);
    #2;
    check("plain_fetch_next", obs, pack(1, 0, 0, 0, 16'h0300, 8'h00));
    model_last = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 16'h0000, 16'h0000, 8'h00);
      #2;
      check("plain_no_dma", obs, pack(0, 0, 0, 0, 16'h0000, 8'h00));
      tick();
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 1, 1, 16'h1234, 16'hABCD, 8'h55, 1, 0, 16'h1234, 0, 8'h00};
    vecs[1]  = '{1, 1, 1, 16'h1234, 16'hABCD, 8'h55, 0, 1, 16'hABCD, 1, 8'h55};
    vecs[2]  = '{1, 1, 0, 16'h2222, 16'h3333, 8'h66, 1, 0, 16'h2222, 0, 8'h00};
    vecs[3]  = '{1, 1, 0, 16'h2222, 16'h3333, 8'h66, 0, 1, 16'h3333, 0, 8'h66};
    vecs[4]  = '{0, 0, 1, 16'h4444, 16'h5555, 8'h77, 0, 0, 16'h0000, 0, 8'h00};
    vecs[5]  = '{0, 1, 1, 16'h4444, 16'h0010, 8'hA5, 0, 1, 16'h0010, 1, 8'hA5};
    vecs[6]  = '{1, 1, 1, 16'h0FFF, 16'h0010, 8'hA5, 1, 0, 16'h0FFF, 0, 8'h00};
    vecs[7]  = '{1, 0, 1, 16'hFFFF, 16'h0010, 8'hA5, 1, 0, 16'hFFFF, 0, 8'h00};
    vecs[8]  = '{1, 1, 1, 16'hFFFF, 16'hFFFF, 8'hFF, 0, 1, 16'hFFFF, 1, 8'hFF};
    vecs[9]  = '{0, 1, 0, 16'h0000, 16'h8000, 8'h01, 0, 1, 16'h8000, 0, 8'h01};
    vecs[10] = '{1, 1, 0, 16'h7777, 16'h8888, 8'h02, 1, 0, 16'h7777, 0, 8'h00};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].f, vecs[i].e, vecs[i].we, vecs[i].fa, vecs[i].ea, vecs[i].wd);
      #2;
      check($sformatf("vec%0d", i), obs,
            pack(vecs[i].efg, vecs[i].eeg, vecs[i].ewe, 0, vecs[i].eaddr, vecs[i].ewd));
      if (vecs[i].efg) model_last = 1'b0;
      if (vecs[i].eeg) model_last = 1'b1;
      tick();
    end

    random_phase(300);

`ifdef OAM_DMA_EN
    run_dma(1'b0);
    run_dma(1'b1);
    run_dma_reset();
`else
    run_plain_trigger();
`endif

    random_phase(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
